nvram_ioctl_port: RTL and testbench
===================================

Name: nvram_ioctl_port

Overview:
- Owns the 2 KB game CMOS/NVRAM image and is the host-side counterpart of the core's ROM-download path.
- Serves data_io uploads ("Save NVRAM", index 8'hFF) by streaming RAM bytes onto ioctl_din.
- Accepts NVRAM restore downloads on the same index.
- Gives the game CPU a private read/write port. Sits beside the arcade core in the MCR2 top level.

Parameters:
- ADDR_W, 11, NVRAM address width (2^ADDR_W bytes).
- NV_INDEX, 8'hFF, ioctl_index value that selects NVRAM transfers.
- FILL, 8'hFF, byte returned for out-of-range upload addresses.

Ports:
- clk_sys  in  1  system clock (all logic on rising edge).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  data_io download active.
- ioctl_upload  in  1  data_io upload active.
- ioctl_index  in  8  transfer index.
- ioctl_wr  in  1  download byte strobe (one clk_sys pulse per byte).
- ioctl_addr  in  25  transfer byte address.
- ioctl_dout  in  8  download data.
- ioctl_din  out  8  upload data to data_io.
- cpu_addr  in  ADDR_W  CPU NVRAM address.
- cpu_we  in  1  CPU write enable.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, 1-cycle latency.
- ul_valid  out  1  ioctl_din is valid for the current ioctl_addr.
- dirty  out  1  CPU has written since the last complete upload or restore.
- restored  out  1  an NVRAM image has been downloaded since reset.

Behaviour:
- Reset: the asynchronous reset_n drives ioctl_din=8'h00, ul_valid=0, dirty=0, restored=0, cpu_dout=8'h00, state=IDLE, byte counter=0. RAM contents are not cleared.
- Selection: sel = (ioctl_index==NV_INDEX). Transfers with any other index are ignored; state stays IDLE and ul_valid stays 0.
- States:
  - IDLE: enter DL on ioctl_download&sel; enter UL_FETCH on ioctl_upload&sel. If both are asserted, download wins.
  - DL: each ioctl_wr with ioctl_addr < 2^ADDR_W writes ioctl_dout to RAM[ioctl_addr[ADDR_W-1:0]]. Writes at higher addresses are dropped. Counter increments per accepted byte.
    - On the download falling edge: go to IDLE; if counter > 0, set restored=1 and clear dirty.
  - UL_FETCH: register ioctl_addr, issue the RAM read, clear ul_valid, go to UL_VALID next cycle.
  - UL_VALID: ioctl_din = RAM data, or FILL if the latched address is ≥ 2^ADDR_W. ul_valid=1.
    - Count each distinct in-range address served.
    - If ioctl_addr differs from the latched address, return to UL_FETCH; ul_valid drops in that same cycle.
    - Latency from address change to ul_valid=1 is exactly 2 clk_sys.
- Upload end: when ioctl_upload falls in UL_FETCH or UL_VALID, go to IDLE. If the counter reached 2^ADDR_W, clear dirty; otherwise dirty is unchanged. ul_valid goes to 0; ioctl_din holds its last value.
- Counter reset: the counter resets to 0 on every entry into DL or UL_FETCH from IDLE.
- CPU port:
  - Always active. On cpu_we, RAM[cpu_addr] <= cpu_din and dirty is set (1 cycle later).
  - cpu_dout = RAM[cpu_addr] one cycle later (read-first on the same port).
- Collisions:
  - A DL write and a CPU write in the same cycle and same address: the download value persists and dirty is not set by that CPU write.
  - A CPU write during upload is accepted and sets dirty. The counter-based dirty clear at upload end still applies, because that data has already left.
- Dirty set versus clear: a CPU write in the same cycle as a dirty clear takes priority, so dirty=1.
- Reset mid-transfer: the FSM returns to IDLE immediately. A partial DL or UL is not counted.

Decomposition:
- Shared package nvram_pkg holds:
  - state enum {IDLE, DL, UL_FETCH, UL_VALID};
  - NV_INDEX_DEFAULT=8'hFF;
  - FILL_DEFAULT=8'hFF.
- One sub-module, nvram_dpram: true dual-port 2^ADDR_W x 8 synchronous RAM with 1-cycle registered reads.
  - Port A: ioctl side, shared by DL writes and UL reads.
  - Port B: CPU side.
- Write-collision arbitration lives in nvram_ioctl_port, not in the RAM.

Test Plan:
- Restore: download index FF, bytes 0x00..0x7FF = addr[7:0], then CPU reads addr 0x123 -> cpu_dout=8'h23 one cycle later; restored=1, dirty=0.
- Ignored index: download index 0 with ioctl_wr at addr 5 -> RAM[5] unchanged, restored stays 0, ul_valid stays 0.
- Upload latency: upload index FF, step ioctl_addr 0..0x7FF holding each 4 cycles -> ul_valid rises exactly 2 cycles after each change and ioctl_din matches RAM; at the end dirty clears from 1 to 0.
- Out-of-range and partial upload: with dirty=1, upload addrs 0x7FE, 0x7FF, 0x800 -> ioctl_din=RAM[0x7FE], RAM[0x7FF], then 8'hFF; upload then ends with only 2 in-range bytes, so dirty stays 1.
- Collision: during DL, ioctl_wr addr 0x10 data 0xAA in the same cycle as cpu_we addr 0x10 data 0x55 -> RAM[0x10]=0xAA, dirty not set by that write.
- Reset mid-upload: deassert reset_n while in UL_VALID -> ul_valid=0 and ioctl_din=0 asynchronously; the FSM stays IDLE after release until a new upload edge.

Source files
------------

// File: rtl/nvram_pkg.sv
// Shared types and defaults for the NVRAM save/restore port.
// Pure declarations: no latency, no flow control.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DL       = 2'd1,
    UL_FETCH = 2'd2,
    UL_VALID = 2'd3
  } nv_state_e;

  localparam logic [7:0] NV_INDEX_DEFAULT = 8'hFF;
  localparam logic [7:0] FILL_DEFAULT     = 8'hFF;

endpackage

// File: rtl/nvram_dpram.sv
// True dual-port 2^ADDR_W x 8 RAM; port A is the ioctl side, port B the CPU side.
// Latency: 1-cycle registered read-first outputs on both ports; no backpressure.
module nvram_dpram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [7:0]        a_din,
  output logic [7:0]        a_dout,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [7:0]        b_din,
  output logic [7:0]        b_dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [0:DEPTH-1];

  // Contents survive reset; only the read registers are cleared.
  always_ff @(posedge clk_sys) begin
    if (b_we) mem[b_addr] <= b_din;
    if (a_we) mem[a_addr] <= a_din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      a_dout <= 8'h00;
      b_dout <= 8'h00;
    end else begin
      a_dout <= mem[a_addr];
      b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/nvram_ioctl_port.sv
// Game NVRAM image with data_io save (upload) / restore (download) on NV_INDEX and a private CPU port.
// Latency: CPU read 1 cycle, upload byte valid 2 cycles after an address change; no backpressure on either side.
module nvram_ioctl_port
  import nvram_pkg::*;
#(
  parameter int         ADDR_W   = 11,
  parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT,
  parameter logic [7:0] FILL     = FILL_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              ul_valid,
  output logic              dirty,
  output logic              restored
);

  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  nv_state_e       state;
  logic [ADDR_W:0] cnt;
  logic [24:0]     lat_addr;
  logic [24:0]     rd_addr_q;
  logic            dl_prev, ul_prev;
  logic [7:0]      a_dout;

  logic sel, dl_lvl, ul_lvl, dl_rise, ul_rise;
  logic addr_in_range, addr_stable, dl_we, cpu_collide, cpu_we_eff;
  logic dl_end, ul_end, dirty_set, dirty_clr;

  assign sel           = (ioctl_index == NV_INDEX);
  assign dl_lvl        = ioctl_download & sel;
  assign ul_lvl        = ioctl_upload & sel;
  assign dl_rise       = dl_lvl & ~dl_prev;
  assign ul_rise       = ul_lvl & ~ul_prev;
  assign addr_in_range = ~|ioctl_addr[24:ADDR_W];
  // a_dout always reflects rd_addr_q, so a stable address means the read data is for it.
  assign addr_stable   = (ioctl_addr == rd_addr_q);

  assign dl_we       = (state == DL) && ioctl_wr && addr_in_range;
  assign cpu_collide = dl_we && cpu_we && (cpu_addr == ioctl_addr[ADDR_W-1:0]);
  assign cpu_we_eff  = cpu_we && !cpu_collide;

  assign dl_end    = (state == DL) && !ioctl_download;
  assign ul_end    = ((state == UL_FETCH) || (state == UL_VALID)) && !ioctl_upload;
  assign dirty_set = cpu_we_eff;
  assign dirty_clr = (dl_end && (cnt != '0)) || (ul_end && (cnt == CNT_FULL));

  assign ul_valid = (state == UL_VALID) && ioctl_upload && (ioctl_addr == lat_addr);

  nvram_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .a_addr  (ioctl_addr[ADDR_W-1:0]),
    .a_we    (dl_we),
    .a_din   (ioctl_dout),
    .a_dout  (a_dout),
    .b_addr  (cpu_addr),
    .b_we    (cpu_we_eff),
    .b_din   (cpu_din),
    .b_dout  (cpu_dout)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      rd_addr_q <= '0;
      ioctl_din <= 8'h00;
      dirty     <= 1'b0;
      restored  <= 1'b0;
      // Start "high" so a transfer left asserted across reset needs a fresh edge.
      dl_prev   <= 1'b1;
      ul_prev   <= 1'b1;
    end else begin
      dl_prev   <= dl_lvl;
      ul_prev   <= ul_lvl;
      rd_addr_q <= ioctl_addr;

      if (dirty_set)      dirty <= 1'b1;
      else if (dirty_clr) dirty <= 1'b0;

      case (state)
        IDLE: begin
          if (dl_rise) begin
            state <= DL;
            cnt   <= '0;
          end else if (ul_rise) begin
            state <= UL_FETCH;
            cnt   <= '0;
          end
        end
        DL: begin
          if (dl_end) begin
            state <= IDLE;
            if (cnt != '0) restored <= 1'b1;
          end else if (dl_we && (cnt != CNT_FULL)) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        UL_FETCH: begin
          if (ul_end) begin
            state <= IDLE;
          end else if (addr_stable) begin
            state     <= UL_VALID;
            lat_addr  <= ioctl_addr;
            ioctl_din <= addr_in_range ? a_dout : FILL;
            if (addr_in_range && (cnt != CNT_FULL)) cnt <= cnt + CNT_ONE;
          end
        end
        UL_VALID: begin
          if (ul_end)                        state <= IDLE;
          else if (ioctl_addr != lat_addr)   state <= UL_FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_ioctl_port.sv
// Directed bench for nvram_ioctl_port: restore, ignored index, upload timing, collisions, reset.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_nvram_ioctl_port;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_upload, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout, ioctl_din;
  logic [24:0] ioctl_addr;
  logic [10:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din, cpu_dout;
  logic        ul_valid, dirty, restored;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] model [0:2047];

  always #5 clk_sys = ~clk_sys;

  nvram_ioctl_port dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_upload   (ioctl_upload),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_din      (ioctl_din),
    .cpu_addr       (cpu_addr),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .ul_valid       (ul_valid),
    .dirty          (dirty),
    .restored       (restored)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'h00; ioctl_dout = 8'h00; ioctl_addr = '0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_din = 8'h00;
    #1;
    chk_cnt++; if (ioctl_din !== 8'h00) $display("FAIL reset_din: got %h want 00", ioctl_din); else pass_cnt++;
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL reset_ul_valid: got %b want 0", ul_valid); else pass_cnt++;
    chk_cnt++; if (dirty !== 1'b0) $display("FAIL reset_dirty: got %b want 0", dirty); else pass_cnt++;
    chk_cnt++; if (restored !== 1'b0) $display("FAIL reset_restored: got %b want 0", restored); else pass_cnt++;
    chk_cnt++; if (cpu_dout !== 8'h00) $display("FAIL reset_cpu_dout: got %h want 00", cpu_dout); else pass_cnt++;
    #20 reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_ignored_index();
    cpu_we = 1'b1; cpu_addr = 11'h005; cpu_din = 8'h3C;
    tick();
    cpu_we = 1'b0; model[5] = 8'h3C;
    chk_cnt++; if (dirty !== 1'b1) $display("FAIL ign_cpu_dirty: got %b want 1", dirty); else pass_cnt++;
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h5; ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL ign_dl_ul_valid: got %b want 0", ul_valid); else pass_cnt++;
    ioctl_download = 1'b0;
    tick(); tick();
    chk_cnt++; if (restored !== 1'b0) $display("FAIL ign_restored: got %b want 0", restored); else pass_cnt++;
    ioctl_upload = 1'b1;
    tick(); tick(); tick();
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL ign_ul_valid: got %b want 0", ul_valid); else pass_cnt++;
    ioctl_upload = 1'b0;
    cpu_addr = 11'h005;
    tick();
    chk_cnt++; if (cpu_dout !== 8'h3C) $display("FAIL ign_ram5: got %h want 3c", cpu_dout); else pass_cnt++;
  endtask

  task automatic test_restore();
    logic [10:0] a11;
    ioctl_index = 8'hFF; ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 2048; a++) begin
      a11 = 11'(a);
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = a11[7:0];
      model[a] = a11[7:0];
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    chk_cnt++; if (restored !== 1'b1) $display("FAIL restore_restored: got %b want 1", restored); else pass_cnt++;
    chk_cnt++; if (dirty !== 1'b0) $display("FAIL restore_dirty: got %b want 0", dirty); else pass_cnt++;
    cpu_addr = 11'h123;
    tick();
    chk_cnt++; if (cpu_dout !== 8'h23) $display("FAIL restore_cpu_123: got %h want 23", cpu_dout); else pass_cnt++;
    cpu_addr = 11'h005;
    tick();
    chk_cnt++; if (cpu_dout !== 8'h05) $display("FAIL restore_cpu_005: got %h want 05", cpu_dout); else pass_cnt++;
  endtask

  task automatic test_upload_full();
    cpu_we = 1'b1; cpu_addr = 11'h400; cpu_din = 8'hC3;
    tick();
    cpu_we = 1'b0; model[11'h400] = 8'hC3;
    chk_cnt++; if (dirty !== 1'b1) $display("FAIL ul_pre_dirty: got %b want 1", dirty); else pass_cnt++;
    ioctl_index = 8'hFF; ioctl_upload = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      ioctl_addr = 25'(a);
      if (a == 256) begin
        cpu_we = 1'b1; cpu_addr = 11'h010; cpu_din = 8'h5A;
      end
      tick();
      cpu_we = 1'b0;
      if (a == 256) begin
        model[16] = 8'h5A;
        chk_cnt++; if (dirty !== 1'b1) $display("FAIL ul_mid_dirty: got %b want 1", dirty); else pass_cnt++;
      end
      chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL ul_lat1 @%h: got %b want 0", a, ul_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (ul_valid !== 1'b1) $display("FAIL ul_lat2 @%h: got %b want 1", a, ul_valid); else pass_cnt++;
      chk_cnt++; if (ioctl_din !== model[a]) $display("FAIL ul_data @%h: got %h want %h", a, ioctl_din, model[a]); else pass_cnt++;
      tick(); tick();
    end
    ioctl_upload = 1'b0;
    tick();
    chk_cnt++; if (dirty !== 1'b0) $display("FAIL ul_end_dirty: got %b want 0", dirty); else pass_cnt++;
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL ul_end_valid: got %b want 0", ul_valid); else pass_cnt++;
    chk_cnt++; if (ioctl_din !== model[2047]) $display("FAIL ul_end_din: got %h want %h", ioctl_din, model[2047]); else pass_cnt++;
  endtask

  task automatic test_collision();
    ioctl_index = 8'hFF; ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hAA;
    cpu_we = 1'b1; cpu_addr = 11'h010; cpu_din = 8'h55;
    tick();
    cpu_we = 1'b0; model[16] = 8'hAA;
    chk_cnt++; if (dirty !== 1'b0) $display("FAIL coll_dirty: got %b want 0", dirty); else pass_cnt++;
    ioctl_addr = 25'h800; ioctl_dout = 8'h01;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    cpu_addr = 11'h010;
    tick();
    chk_cnt++; if (cpu_dout !== 8'hAA) $display("FAIL coll_ram10: got %h want aa", cpu_dout); else pass_cnt++;
    cpu_addr = 11'h000;
    tick();
    chk_cnt++; if (cpu_dout !== model[0]) $display("FAIL oor_dl_ram0: got %h want %h", cpu_dout, model[0]); else pass_cnt++;
    chk_cnt++; if (dirty !== 1'b0) $display("FAIL coll_end_dirty: got %b want 0", dirty); else pass_cnt++;
  endtask

  task automatic test_partial_upload();
    logic [24:0] addrs [3];
    logic [7:0]  exp_din [3];
    cpu_we = 1'b1; cpu_addr = 11'h7FE; cpu_din = 8'h11;
    tick();
    chk_cnt++; if (cpu_dout !== 8'hFE) $display("FAIL cpu_read_first: got %h want fe", cpu_dout); else pass_cnt++;
    cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_din = 8'h22;
    tick();
    cpu_we = 1'b0; cpu_addr = 11'h7FE;
    tick();
    chk_cnt++; if (cpu_dout !== 8'h11) $display("FAIL cpu_after_write: got %h want 11", cpu_dout); else pass_cnt++;
    chk_cnt++; if (dirty !== 1'b1) $display("FAIL part_pre_dirty: got %b want 1", dirty); else pass_cnt++;
    addrs[0] = 25'h7FE; addrs[1] = 25'h7FF; addrs[2] = 25'h800;
    exp_din[0] = 8'h11; exp_din[1] = 8'h22; exp_din[2] = 8'hFF;
    ioctl_index = 8'hFF; ioctl_upload = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = addrs[i];
      tick();
      chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL part_lat1 #%0d: got %b want 0", i, ul_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (ul_valid !== 1'b1) $display("FAIL part_lat2 #%0d: got %b want 1", i, ul_valid); else pass_cnt++;
      chk_cnt++; if (ioctl_din !== exp_din[i]) $display("FAIL part_data #%0d: got %h want %h", i, ioctl_din, exp_din[i]); else pass_cnt++;
      tick(); tick();
    end
    ioctl_upload = 1'b0;
    tick();
    chk_cnt++; if (dirty !== 1'b1) $display("FAIL part_end_dirty: got %b want 1", dirty); else pass_cnt++;
    chk_cnt++; if (ioctl_din !== 8'hFF) $display("FAIL part_end_din: got %h want ff", ioctl_din); else pass_cnt++;
  endtask

  task automatic test_reset_mid_upload();
    ioctl_index = 8'hFF; ioctl_upload = 1'b1; ioctl_addr = 25'h10;
    tick(); tick();
    chk_cnt++; if (ul_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", ul_valid); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", ul_valid); else pass_cnt++;
    chk_cnt++; if (ioctl_din !== 8'h00) $display("FAIL rst_async_din: got %h want 00", ioctl_din); else pass_cnt++;
    chk_cnt++; if (dirty !== 1'b0) $display("FAIL rst_dirty: got %b want 0", dirty); else pass_cnt++;
    chk_cnt++; if (restored !== 1'b0) $display("FAIL rst_restored: got %b want 0", restored); else pass_cnt++;
    #10 reset_n = 1'b1;
    tick(); tick(); tick();
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL rst_stay_idle: got %b want 0", ul_valid); else pass_cnt++;
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    chk_cnt++; if (ul_valid !== 1'b0) $display("FAIL rst_new_lat1: got %b want 0", ul_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (ul_valid !== 1'b1) $display("FAIL rst_new_lat2: got %b want 1", ul_valid); else pass_cnt++;
    chk_cnt++; if (ioctl_din !== model[16]) $display("FAIL rst_ram_kept: got %h want %h", ioctl_din, model[16]); else pass_cnt++;
    ioctl_upload = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ignored_index();
    test_restore();
    test_upload_full();
    test_collision();
    test_partial_upload();
    test_reset_mid_upload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
